uart_tx_arbiter: RTL and testbench

Packet-level round-robin arbiter that shares one `uart_tx` serializer between `N_REQ` byte-stream requesters (e.g. sample dump, status reporter, command echo). Each requester presents bytes on a valid/ready handshake with a `last` flag. The arbiter grants one requester for a whole packet and feeds its bytes to `uart_tx` one at a time, waiting for `done` between bytes. A gap watchdog releases a grant whose requester stalls mid-packet.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_tx_arbiter_if.sv | 33 +++
 rtl/uart_tx_arbiter_rr_pick.sv | 33 +++
 rtl/uart_tx_arbiter.sv | 132 +++++++++++++
 tb/tb_uart_tx_arbiter.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit-side blocks.
//   BYTE_W      : width of one serialized byte
//   arb_state_t : arbiter state encoding (IDLE, GRANT, WAIT)
package uart_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        WAIT  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side bundle for uart_tx_arbiter: one valid/ready/last byte
// stream per requester, packed side by side.
//   req_valid [N_REQ]        : byte valid, one bit per requester
//   req_data  [N_REQ*BYTE_W] : byte of requester i at [8i+7:8i]
//   req_last  [N_REQ]        : byte closes its packet
//   req_ready [N_REQ]        : byte accepted when valid and ready are high
// master = requesters, slave = arbiter.
interface uart_tx_arbiter_if
    import uart_pkg::*;
#(
    parameter int N_REQ = 4
) ();

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ*BYTE_W-1:0] req_data;
    logic [N_REQ-1:0]        req_last;
    logic [N_REQ-1:0]        req_ready;

    modport master (
        output req_valid,
        output req_data,
        output req_last,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_data,
        input  req_last,
        output req_ready
    );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin first-one finder.
//   req [N] : request vector
//   ptr [W] : index with highest priority; search wraps upward from here
//   idx [W] : first set request at or after ptr (0 when none)
//   any     : at least one request is set
module rr_pick #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         any
);

    always_comb begin
        logic found;
        int   j;
        found = 1'b0;
        idx   = '0;
        j     = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!found && req[j]) begin
                idx   = W'(j);
                found = 1'b1;
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one uart_tx serializer between
// N_REQ byte-stream requesters. A grant lasts a whole packet; bytes go to
// uart_tx one at a time, waiting for tx_done between them. A gap watchdog
// revokes a grant whose requester stalls mid-packet.
//   clk, rst   : clock, synchronous active-high reset
//   req_if     : requester valid/data/last/ready bundle (slave side)
//   tx_start   : one-cycle start pulse to uart_tx
//   tx_data    : byte to uart_tx, held from tx_start until tx_done
//   tx_done    : one-cycle done pulse from uart_tx
//   tx_active  : uart_tx busy
//   grant_id   : currently or last granted requester
//   busy       : arbiter not idle
//   gap_err    : sticky watchdog-revoke flag, cleared only by rst
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int  N_REQ   = 4,
    parameter int  GAP_MAX = 4096,
    localparam int ID_W    = $clog2(N_REQ),
    localparam int GAP_W   = $clog2(GAP_MAX + 1)
) (
    input  logic              clk,
    input  logic              rst,
    uart_tx_arbiter_if.slave  req_if,
    output logic              tx_start,
    output logic [BYTE_W-1:0] tx_data,
    input  logic              tx_done,
    input  logic              tx_active,
    output logic [ID_W-1:0]   grant_id,
    output logic              busy,
    output logic              gap_err
);

    arb_state_t        state, state_nxt;
    logic [ID_W-1:0]   grant_nxt, rr_ptr, rr_nxt, pick_idx, grant_inc;
    logic [GAP_W-1:0]  gap_cnt, gap_nxt;
    logic [BYTE_W-1:0] data_nxt, grant_byte;
    logic [N_REQ-1:0]  ready;
    logic              pick_any, grant_valid;
    logic              last_q, last_nxt, start_nxt, gap_err_nxt;

    rr_pick #(
        .N (N_REQ),
        .W (ID_W)
    ) u_pick (
        .req (req_if.req_valid),
        .ptr (rr_ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign grant_valid      = req_if.req_valid[grant_id];
    assign grant_byte       = req_if.req_data[BYTE_W*int'(grant_id) +: BYTE_W];
    // Pointer lands just past the served requester so it ranks last next time.
    assign grant_inc        = (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
    assign busy             = (state != IDLE);
    assign req_if.req_ready = ready;

    always_comb begin
        state_nxt   = state;
        grant_nxt   = grant_id;
        rr_nxt      = rr_ptr;
        gap_nxt     = gap_cnt;
        last_nxt    = last_q;
        start_nxt   = 1'b0;
        data_nxt    = tx_data;
        gap_err_nxt = gap_err;
        ready       = '0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    grant_nxt = pick_idx;
                    gap_nxt   = '0;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                ready[grant_id] = grant_valid && !tx_active;
                if (grant_valid && !tx_active) begin
                    start_nxt = 1'b1;
                    data_nxt  = grant_byte;
                    last_nxt  = req_if.req_last[grant_id];
                    state_nxt = WAIT;
                end else if (!grant_valid) begin
                    // Counter stops at the revoke threshold, so it never wraps.
                    if (gap_cnt >= GAP_W'(GAP_MAX - 1)) begin
                        gap_err_nxt = 1'b1;
                        rr_nxt      = grant_inc;
                        state_nxt   = IDLE;
                    end else begin
                        gap_nxt = gap_cnt + 1'b1;
                    end
                end
            end
            WAIT: begin
                if (tx_done) begin
                    if (last_q) begin
                        rr_nxt    = grant_inc;
                        state_nxt = IDLE;
                    end else begin
                        gap_nxt   = '0;
                        state_nxt = GRANT;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            grant_id <= '0;
            rr_ptr   <= '0;
            gap_cnt  <= '0;
            last_q   <= 1'b0;
            tx_start <= 1'b0;
            tx_data  <= '0;
            gap_err  <= 1'b0;
        end else begin
            state    <= state_nxt;
            grant_id <= grant_nxt;
            rr_ptr   <= rr_nxt;
            gap_cnt  <= gap_nxt;
            last_q   <= last_nxt;
            tx_start <= start_nxt;
            tx_data  <= data_nxt;
            gap_err  <= gap_err_nxt;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural uart_tx model
// (CLKS_PER_BIT=4, 10 bit times per byte) and an ordered byte scoreboard.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int N        = 4;
    localparam int GAP      = 16;
    localparam int CPB      = 4;
    localparam int BYTE_CYC = CPB * 10;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_done   = 1'b0;
    logic       tx_active = 1'b0;
    logic [1:0] grant_id;
    logic       busy;
    logic       gap_err;

    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.N_REQ(N)) rif ();

    uart_tx_arbiter #(
        .N_REQ   (N),
        .GAP_MAX (GAP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_if    (rif),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_done   (tx_done),
        .tx_active (tx_active),
        .grant_id  (grant_id),
        .busy      (busy),
        .gap_err   (gap_err)
    );

    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    logic [8:0] rq [N][$];
    logic [9:0] exp_q [$];
    bit         u_busy = 0;
    int         u_cnt = 0;
    logic [7:0] u_byte = '0;
    int         last_start_cyc = 0;
    int         last_done_cyc = 0;
    int         gap_err_cyc = -1;
    int         n_starts = 0;
    int         n_dones = 0;
    bit         prev_start = 0;
    bit         watch_r0 = 0;
    logic       r0_or = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic refresh();
        logic [8:0] head;
        for (int i = 0; i < N; i++) begin
            if (rq[i].size() > 0) begin
                head = rq[i][0];
                rif.req_valid[i]         = 1'b1;
                rif.req_data[8*i +: 8]   = head[7:0];
                rif.req_last[i]          = head[8];
            end else begin
                rif.req_valid[i]         = 1'b0;
                rif.req_data[8*i +: 8]   = 8'h00;
                rif.req_last[i]          = 1'b0;
            end
        end
    endtask

    task automatic tick();
        logic [N-1:0] hs;
        logic [9:0]   e;
        hs = rif.req_ready & rif.req_valid;
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            u_busy    = 0;
            tx_active = 1'b0;
            tx_done   = 1'b0;
        end else begin
            tx_done = 1'b0;
            if (u_busy) begin
                u_cnt--;
                if (u_cnt == 0) begin
                    check("data_hold", tx_data, u_byte);
                    tx_done       = 1'b1;
                    tx_active     = 1'b0;
                    u_busy        = 0;
                    last_done_cyc = cyc;
                    n_dones++;
                end
            end
            if (tx_start) begin
                check("start_back2back", prev_start, 0);
                if (exp_q.size() == 0) begin
                    check("sb_underflow", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_data", tx_data, e[7:0]);
                    check("sb_grant", grant_id, e[9:8]);
                end
                u_busy         = 1;
                tx_active      = 1'b1;
                u_cnt          = BYTE_CYC;
                u_byte         = tx_data;
                last_start_cyc = cyc;
                n_starts++;
            end
        end
        prev_start = tx_start;
        for (int i = 0; i < N; i++)
            if (hs[i]) void'(rq[i].pop_front());
        refresh();
        if (gap_err && gap_err_cyc < 0) gap_err_cyc = cyc;
        if (watch_r0) r0_or = r0_or | rif.req_ready[0];
    endtask

    task automatic wait_starts(input int target);
        int k = 0;
        while (n_starts < target && k < 300) begin
            tick();
            k++;
        end
        check("wait_start", n_starts, target);
    endtask

    task automatic wait_dones(input int target);
        int k = 0;
        while (n_dones < target && k < 300) begin
            tick();
            k++;
        end
        check("wait_done", n_dones, target);
    endtask

    task automatic drain();
        int k = 0;
        while ((exp_q.size() != 0 || u_busy) && k < 1000) begin
            tick();
            k++;
        end
        check("drain_left", exp_q.size() + int'(u_busy), 0);
        repeat (3) tick();
    endtask

    initial begin
        int t0, base, k;
        rif.req_valid = '0;
        rif.req_data  = '0;
        rif.req_last  = '0;

        // reset values
        rst = 1'b1;
        repeat (3) tick();
        check("rst_ready", rif.req_ready, 0);
        check("rst_start", tx_start, 0);
        check("rst_data", tx_data, 0);
        check("rst_grant", grant_id, 0);
        check("rst_busy", busy, 0);
        check("rst_gap_err", gap_err, 0);
        rst = 1'b0;
        tick();

        // round-robin fairness: all four from reset, then 0 and 3
        for (int i = 0; i < N; i++) begin
            rq[i].push_back({1'b1, 8'h10 + 8'(i)});
            exp_q.push_back({2'(i), 8'h10 + 8'(i)});
        end
        refresh();
        drain();
        rq[0].push_back({1'b1, 8'h20});
        rq[3].push_back({1'b1, 8'h23});
        exp_q.push_back({2'd0, 8'h20});
        exp_q.push_back({2'd3, 8'h23});
        refresh();
        drain();

        // single two-byte packet from requester 2, with latency checks
        base = n_starts;
        rq[2].push_back({1'b0, 8'hAB});
        rq[2].push_back({1'b1, 8'hCD});
        exp_q.push_back({2'd2, 8'hAB});
        exp_q.push_back({2'd2, 8'hCD});
        refresh();
        t0 = cyc;
        wait_starts(base + 1);
        check("lat_valid_to_start", last_start_cyc - t0, 2);
        wait_starts(base + 2);
        check("lat_inter_byte", last_start_cyc - last_done_cyc, 2);
        base = n_dones;
        wait_dones(base + 1);
        check("busy_at_last_done", busy, 1);
        tick();
        check("busy_after_last_done", busy, 0);
        drain();

        // packet atomicity: requester 1 three bytes, requester 0 waits
        rq[1].push_back({1'b0, 8'h01});
        rq[1].push_back({1'b0, 8'h02});
        rq[1].push_back({1'b1, 8'h03});
        exp_q.push_back({2'd1, 8'h01});
        exp_q.push_back({2'd1, 8'h02});
        exp_q.push_back({2'd1, 8'h03});
        refresh();
        base = n_dones;
        tick();
        rq[0].push_back({1'b1, 8'h0F});
        exp_q.push_back({2'd0, 8'h0F});
        refresh();
        r0_or    = 1'b0;
        watch_r0 = 1;
        wait_dones(base + 3);
        watch_r0 = 0;
        check("atom_ready0", r0_or, 0);
        drain();

        // gap watchdog: requester 3 stalls after a non-last byte
        rq[3].push_back({1'b0, 8'h55});
        exp_q.push_back({2'd3, 8'h55});
        refresh();
        base = n_dones;
        tick();
        rq[0].push_back({1'b1, 8'h40});
        exp_q.push_back({2'd0, 8'h40});
        refresh();
        wait_dones(base + 1);
        t0 = last_done_cyc;
        k  = 0;
        while (gap_err_cyc < 0 && k < 60) begin
            tick();
            k++;
        end
        check("gap_revoke_cyc", gap_err_cyc - t0, 17);
        check("gap_err_set", gap_err, 1);
        check("gap_busy_idle", busy, 0);
        drain();
        check("gap_err_sticky", gap_err, 1);

        // reset mid-byte, then a fresh packet from requester 1
        base = n_starts;
        rq[2].push_back({1'b1, 8'h99});
        exp_q.push_back({2'd2, 8'h99});
        refresh();
        wait_starts(base + 1);
        repeat (3) tick();
        check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        tick();
        check("mid_rst_ready", rif.req_ready, 0);
        check("mid_rst_start", tx_start, 0);
        check("mid_rst_data", tx_data, 0);
        check("mid_rst_grant", grant_id, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_gap_err", gap_err, 0);
        rst = 1'b0;
        base = n_starts;
        rq[1].push_back({1'b1, 8'h7E});
        exp_q.push_back({2'd1, 8'h7E});
        refresh();
        t0 = cyc;
        wait_starts(base + 1);
        check("post_rst_latency", last_start_cyc - t0, 2);
        drain();
        check("sb_empty_end", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
